param_control_unit: RTL and testbench

PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

---
 rtl/param_control_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_param_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_control_unit.sv
// Instruction sequencer: FETCH/DECODE/OPND1/OPND2/MEM/EXEC control for a small accumulator-less CPU.
// Optional single-step gating of instruction fetch is built when CTRL_STEP_EN is defined.
module param_control_unit #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    input  logic [3:0]        ccr,
    input  logic              step_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic              addr_sel,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              rf_we,
    output logic [1:0]        wdata_sel,
    output logic [3:0]        alu_sel,
    output logic              ccr_load,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] addr_out,
    output logic              illegal,
    output logic              busy
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, OPND1 = 3'd2, OPND2 = 3'd3, MEM = 3'd4, EXEC = 3'd5
    } state_t;

`ifdef CTRL_STEP_EN
    localparam logic STEP_EN = 1'b1;
    logic step_s;
    assign step_s = step_req;
`else
    localparam logic STEP_EN = 1'b0;
    logic step_unused_s;
    logic step_s;
    assign step_unused_s = step_req;
    assign step_s = 1'b0;
`endif

    function automatic logic op_legal(input logic [7:0] op);
        case (op)
            8'h80, 8'h81, 8'h82, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94,
            8'hA0, 8'hA1, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24,
            8'h25, 8'h26, 8'h27, 8'h28: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [7:0] op);
        case (op)
            8'h90:   alu_code = 4'd0;
            8'h91:   alu_code = 4'd1;
            8'h92:   alu_code = 4'd4;
            8'h93:   alu_code = 4'd5;
            8'h94:   alu_code = 4'd6;
            8'hA0:   alu_code = 4'd7;
            8'hA1:   alu_code = 4'd8;
            default: alu_code = 4'd0;
        endcase
    endfunction

    // Flags are {N,Z,V,C}; condition index is the branch opcode's low nibble.
    function automatic logic br_taken(input logic [3:0] cond, input logic [3:0] f);
        case (cond)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = ~f[0];
            4'd2:    br_taken = f[0];
            4'd3:    br_taken = ~f[2];
            4'd4:    br_taken = f[2];
            4'd5:    br_taken = ~f[3];
            4'd6:    br_taken = f[3];
            4'd7:    br_taken = ~f[1];
            4'd8:    br_taken = f[1];
            default: br_taken = 1'b0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   imm_q, imm_d, addr_q, addr_d, imm_out_q, imm_out_d;
    logic                go_q, go_d, acc_s;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d, addr_sel_q, addr_sel_d;
    logic                inc_en_q, inc_en_d, fetch_en_q, fetch_en_d, ld_en_q, ld_en_d;
    logic                pc_load_q, pc_load_d, rf_we_q, rf_we_d, ccr_load_q, ccr_load_d;
    logic                illegal_q, illegal_d, busy_q, busy_d;
    logic [REG_AW-1:0]   raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d, waddr_q, waddr_d;
    logic [1:0]          wdata_sel_q, wdata_sel_d;
    logic [3:0]          alu_sel_q, alu_sel_d;

    // Next state, operand capture, and next-cycle output decode from the next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        addr_d  = addr_q;
        go_d    = go_q;
        acc_s   = mem_req_q & mem_rdy;
        case (state_q)
            FETCH: begin
                if (!go_q) go_d = step_s | ~STEP_EN;
                else       go_d = go_q;
                if (acc_s) begin
                    state_d = DECODE;
                    ir_d    = mem_rdata[7:0];
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                if (op_legal(ir_q)) begin
                    state_d = OPND1;
                end else begin
                    state_d = FETCH;
                    go_d    = ~STEP_EN;
                end
            end
            OPND1: begin
                if (acc_s) begin
                    imm_d   = mem_rdata;
                    state_d = (ir_q[7:4] == 4'h8 || ir_q[7:4] == 4'h9) ? OPND2 : EXEC;
                end else begin
                    state_d = OPND1;
                end
            end
            OPND2: begin
                if (acc_s) begin
                    addr_d  = mem_rdata;
                    state_d = (ir_q == 8'h81 || ir_q == 8'h82) ? MEM : EXEC;
                end else begin
                    state_d = OPND2;
                end
            end
            MEM: begin
                if (acc_s) state_d = EXEC;
                else       state_d = MEM;
            end
            EXEC: begin
                state_d = FETCH;
                go_d    = ~STEP_EN;
            end
            default: state_d = FETCH;
        endcase

        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        addr_sel_d  = 1'b0;
        inc_en_d    = 1'b0;
        fetch_en_d  = 1'b0;
        ld_en_d     = 1'b0;
        pc_load_d   = 1'b0;
        rf_we_d     = 1'b0;
        ccr_load_d  = 1'b0;
        illegal_d   = 1'b0;
        busy_d      = 1'b1;
        raddr_a_d   = {REG_AW{1'b0}};
        raddr_b_d   = {REG_AW{1'b0}};
        waddr_d     = {REG_AW{1'b0}};
        wdata_sel_d = 2'd0;
        alu_sel_d   = 4'd0;
        imm_out_d   = imm_d;
        case (state_d)
            FETCH: begin
                mem_req_d  = go_d;
                inc_en_d   = go_d;
                fetch_en_d = go_d;
                busy_d     = go_d;
            end
            DECODE: illegal_d = ~op_legal(ir_d);
            OPND1, OPND2: begin
                mem_req_d = 1'b1;
                inc_en_d  = 1'b1;
            end
            MEM: begin
                mem_req_d  = 1'b1;
                addr_sel_d = 1'b1;
                if (ir_d == 8'h82) begin
                    mem_we_d  = 1'b1;
                    raddr_a_d = imm_d[REG_AW-1:0];
                end else begin
                    ld_en_d     = 1'b1;
                    wdata_sel_d = 2'd2;
                    waddr_d     = imm_d[REG_AW-1:0];
                end
            end
            EXEC: begin
                case (ir_d[7:4])
                    4'h8: begin
                        // LDI: the immediate arrives as operand 2 and is shown on imm_out.
                        if (ir_d == 8'h80) begin
                            rf_we_d     = 1'b1;
                            waddr_d     = imm_d[REG_AW-1:0];
                            wdata_sel_d = 2'd1;
                            imm_out_d   = addr_d;
                        end else begin
                            rf_we_d = 1'b0;
                        end
                    end
                    4'h9, 4'hA: begin
                        rf_we_d    = 1'b1;
                        ccr_load_d = 1'b1;
                        raddr_a_d  = imm_d[REG_AW-1:0];
                        raddr_b_d  = addr_d[REG_AW-1:0];
                        waddr_d    = imm_d[REG_AW-1:0];
                        alu_sel_d  = alu_code(ir_d);
                    end
                    4'h2:    pc_load_d = br_taken(ir_d[3:0], ccr);
                    default: pc_load_d = 1'b0;
                endcase
            end
            default: busy_d = 1'b1;
        endcase
    end

    // State, operand and registered-output flops; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            ir_q        <= 8'h00;
            imm_q       <= {DATA_W{1'b0}};
            addr_q      <= {DATA_W{1'b0}};
            imm_out_q   <= {DATA_W{1'b0}};
            go_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_sel_q  <= 1'b0;
            inc_en_q    <= 1'b0;
            fetch_en_q  <= 1'b0;
            ld_en_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            ccr_load_q  <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            raddr_a_q   <= {REG_AW{1'b0}};
            raddr_b_q   <= {REG_AW{1'b0}};
            waddr_q     <= {REG_AW{1'b0}};
            wdata_sel_q <= 2'd0;
            alu_sel_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            imm_q       <= imm_d;
            addr_q      <= addr_d;
            imm_out_q   <= imm_out_d;
            go_q        <= go_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            addr_sel_q  <= addr_sel_d;
            inc_en_q    <= inc_en_d;
            fetch_en_q  <= fetch_en_d;
            ld_en_q     <= ld_en_d;
            pc_load_q   <= pc_load_d;
            rf_we_q     <= rf_we_d;
            ccr_load_q  <= ccr_load_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            raddr_a_q   <= raddr_a_d;
            raddr_b_q   <= raddr_b_d;
            waddr_q     <= waddr_d;
            wdata_sel_q <= wdata_sel_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    // Completion strobes must land in the memory-ready cycle itself.
    assign pc_inc      = inc_en_q & mem_rdy;
    assign ir_load     = fetch_en_q & mem_rdy;
    assign rf_we       = rf_we_q | (ld_en_q & mem_rdy);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign addr_sel    = addr_sel_q;
    assign pc_load     = pc_load_q;
    assign ccr_load    = ccr_load_q;
    assign illegal     = illegal_q;
    assign busy        = busy_q;
    assign rf_raddr_a  = raddr_a_q;
    assign rf_raddr_b  = raddr_b_q;
    assign rf_waddr    = waddr_q;
    assign wdata_sel   = wdata_sel_q;
    assign alu_sel     = alu_sel_q;
    assign imm_out     = imm_out_q;
    assign addr_out    = addr_q;

endmodule

// File: tb/tb_param_control_unit.sv
// Directed bench for param_control_unit: small memory/PC environment plus hand-computed expectations.
module tb_param_control_unit;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic [3:0]    ccr;
    logic          step_req;
    logic          mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic          rf_we;
    logic [1:0]    wdata_sel;
    logic [3:0]    alu_sel;
    logic          ccr_load;
    logic [DW-1:0] imm_out, addr_out;
    logic          illegal, busy;

    param_control_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .ccr(ccr),
        .step_req(step_req), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_raddr_a(rf_raddr_a),
        .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we), .wdata_sel(wdata_sel),
        .alu_sel(alu_sel), .ccr_load(ccr_load), .imm_out(imm_out), .addr_out(addr_out),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_arr [256];
    logic [7:0] pc_m;
    logic [7:0] bus_addr;
    int         wcnt;
    int         wait_n = 0;
    logic       rdy_force = 1'b0;

    assign bus_addr  = addr_sel ? addr_out : pc_m;
    assign mem_rdata = mem_arr[bus_addr];
    assign mem_rdy   = (mem_req && (wcnt == wait_n)) || rdy_force;

    // Environment: program counter datapath and wait-state counter of the memory.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_m <= 8'h00;
            wcnt <= 0;
        end else begin
            if (pc_load)     pc_m <= imm_out;
            else if (pc_inc) pc_m <= pc_m + 8'd1;
            if (mem_req && !mem_rdy) wcnt <= wcnt + 1;
            else                     wcnt <= 0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        mem_arr[0] = b0;
        mem_arr[1] = b1;
        mem_arr[2] = b2;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        step_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    logic [7:0] br_op [6] = '{8'h24, 8'h24, 8'h21, 8'h28, 8'h26, 8'h25};
    logic [3:0] br_f  [6] = '{4'b0100, 4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1000};
    logic       br_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n_a, n_b, n_c;
        logic found;
        ccr = 4'b0000;
        load_prog(8'h80, 8'h03, 8'h5A);
        reset    = 1'b0;
        step_req = 1'b0;
        tick();
        check("rst_mem_req", mem_req, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_imm_out", imm_out, 32'h0);
        check("rst_addr_out", addr_out, 32'h0);
        check("rst_rf_we", rf_we, 32'h0);

`ifdef CTRL_STEP_EN
        mem_arr[3] = 8'h80;
        mem_arr[4] = 8'h05;
        mem_arr[5] = 8'h77;
        do_reset();
        tick();
        tick();
        check("step_idle_req", mem_req, 32'h0);
        check("step_idle_busy", busy, 32'h0);
        step_req = 1'b1;
        n_a = 0;
        n_b = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            step_req = (i == 1);
            #1;
            if (rf_we)   n_a++;
            if (ir_load) n_b++;
        end
        check("step_one_write", n_a, 32'd1);
        check("step_one_fetch", n_b, 32'd1);
        check("step_end_busy", busy, 32'h0);
        check("step_end_pc", pc_m, 32'h3);
`else
        // LDI r3,0x5A with zero wait states.
        do_reset();
        tick();
        check("ldi_f_ir_load", ir_load, 32'h1);
        check("ldi_f_pc_inc", pc_inc, 32'h1);
        check("ldi_f_busy", busy, 32'h1);
        tick();
        check("ldi_d_mem_req", mem_req, 32'h0);
        rdy_force = 1'b1;
        #1;
        check("stray_rdy_pc_inc", pc_inc, 32'h0);
        check("stray_rdy_ir_load", ir_load, 32'h0);
        rdy_force = 1'b0;
        tick();
        check("ldi_o1_pc_inc", pc_inc, 32'h1);
        tick();
        check("ldi_o2_imm", imm_out, 32'h3);
        tick();
        check("ldi_e_rf_we", rf_we, 32'h1);
        check("ldi_e_waddr", rf_waddr, 32'h3);
        check("ldi_e_wsel", wdata_sel, 32'h1);
        check("ldi_e_data", imm_out, 32'h5A);
        tick();
        check("ldi_refetch", ir_load, 32'h1);
        check("ldi_pc", pc_m, 32'h3);

        // ADD r1,r2 with three wait states per access.
        load_prog(8'h90, 8'h01, 8'h02);
        wait_n = 3;
        do_reset();
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mem_req && !mem_rdy) n_a++;
            if (pc_inc) n_b++;
            if (ccr_load) begin
                n_c++;
                check("add_alu", alu_sel, 32'h0);
                check("add_waddr", rf_waddr, 32'h1);
                check("add_raddr_b", rf_raddr_b, 32'h2);
                check("add_rf_we", rf_we, 32'h1);
            end
        end
        check("add_wait_cycles", n_a, 32'd9);
        check("add_pc_incs", n_b, 32'd3);
        check("add_exec_count", n_c, 32'd1);
        tick();
        check("add_pc", pc_m, 32'h3);

        // ST r4,0x40 then LD r(0x12 -> 2),0x30.
        load_prog(8'h82, 8'h04, 8'h40);
        wait_n = 0;
        do_reset();
        n_a = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rf_we) n_a++;
            if (i == 4) begin
                check("st_mem_we", mem_we, 32'h1);
                check("st_addr_sel", addr_sel, 32'h1);
                check("st_addr_out", addr_out, 32'h40);
                check("st_raddr_a", rf_raddr_a, 32'h4);
            end
        end
        check("st_no_rf_we", n_a, 32'd0);
        check("st_e_mem_we", mem_we, 32'h0);

        load_prog(8'h81, 8'h12, 8'h30);
        mem_arr[8'h30] = 8'hC3;
        do_reset();
        repeat (5) tick();
        check("ld_mem_rf_we", rf_we, 32'h1);
        check("ld_mem_wsel", wdata_sel, 32'h2);
        check("ld_mem_waddr", rf_waddr, 32'h2);
        check("ld_mem_data", mem_rdata, 32'hC3);
        tick();
        check("ld_e_no_write", rf_we, 32'h0);

        // DEC r5.
        load_prog(8'hA1, 8'h05, 8'h00);
        do_reset();
        repeat (4) tick();
        check("dec_alu", alu_sel, 32'h8);
        check("dec_waddr", rf_waddr, 32'h5);
        check("dec_ccr_load", ccr_load, 32'h1);

        // Conditional branches to 0x10.
        for (int k = 0; k < 6; k++) begin
            load_prog(br_op[k], 8'h10, 8'h00);
            ccr = br_f[k];
            do_reset();
            repeat (4) tick();
            check($sformatf("br%0d_pc_load", k), pc_load, {31'h0, br_t[k]});
            check($sformatf("br%0d_pc_inc", k), pc_inc, 32'h0);
            tick();
            check($sformatf("br%0d_pc", k), pc_m, br_t[k] ? 32'h10 : 32'h2);
        end
        ccr = 4'b0000;

        // Undefined opcode.
        load_prog(8'hFF, 8'hA0, 8'h05);
        do_reset();
        n_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (illegal) n_a++;
        end
        check("ill_pulses", n_a, 32'd1);
        check("ill_pc", pc_m, 32'h1);
        check("ill_refetch", ir_load, 32'h1);

        // Reset asserted while LD sits in MEM.
        load_prog(8'h81, 8'h02, 8'h30);
        wait_n = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!found) begin
                tick();
                if (addr_sel) found = 1'b1;
            end
        end
        check("rstmem_reached", found, 32'h1);
        reset = 1'b0;
        #1;
        check("rstmem_rf_we", rf_we, 32'h0);
        check("rstmem_mem_req", mem_req, 32'h0);
        check("rstmem_addr_sel", addr_sel, 32'h0);
        n_a = 0;
        repeat (2) begin
            tick();
            if (rf_we || pc_load || mem_we) n_a++;
        end
        reset = 1'b1;
        tick();
        if (rf_we || pc_load || mem_we) n_a++;
        check("rstmem_no_side_effect", n_a, 32'd0);
        check("rstmem_restart_req", mem_req, 32'h1);
        check("rstmem_restart_pc", pc_m, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
